// File: rtl/fp_addsub_issue_ctrl.sv
// Operand issue sequencer for the fpadd unit: feeds A/B/op pairs and
// raises outsider15 in the cycle each pair's sum is valid.
module fp_addsub_issue_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADD_LATENCY = 4,
    parameter int LEN_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  vec_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_op,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              op_out,
    output logic              outsider15,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  issued_cnt,
    output logic [LEN_W-1:0]  result_cnt
);

    // Bit 0 marks operands sitting at A/B; the tail is ADD_LATENCY edges later.
    localparam int PW = ADD_LATENCY + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              start_q;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  issued_q, issued_d;
    logic [LEN_W-1:0]  result_q, result_d;
    logic [PW-1:0]     pipe_q, pipe_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              op_q, op_d;
    logic              launch;
    logic              hs;

    assign launch = start & ~start_q;
    assign hs     = in_valid & in_ready & start;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        pipe_d   = {pipe_q[PW-2:0], hs};
        issued_d = issued_q + {{(LEN_W-1){1'b0}}, hs};
        result_d = result_q + {{(LEN_W-1){1'b0}}, pipe_q[PW-1]};
        a_d      = hs ? in_a  : a_q;
        b_d      = hs ? in_b  : b_q;
        op_d     = hs ? in_op : op_q;

        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    len_d    = vec_len;
                    issued_d = '0;
                    result_d = '0;
                    state_d  = (vec_len == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (issued_d == len_q) state_d = DRAIN;
            end
            DRAIN: begin
                if (pipe_d == '0 && result_d == len_q) state_d = DONE;
            end
            DONE: begin
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything; operands are left untouched.
        if (!start) begin
            state_d  = IDLE;
            pipe_d   = '0;
            issued_d = '0;
            result_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            start_q  <= 1'b0;
            len_q    <= '0;
            issued_q <= '0;
            result_q <= '0;
            pipe_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start;
            len_q    <= len_d;
            issued_q <= issued_d;
            result_q <= result_d;
            pipe_q   <= pipe_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
        end
    end

    assign in_ready   = (state_q == ISSUE);
    assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
    assign done       = (state_q == DONE);
    assign outsider15 = pipe_q[PW-1];
    assign a_out      = a_q;
    assign b_out      = b_q;
    assign op_out     = op_q;
    assign issued_cnt = issued_q;
    assign result_cnt = result_q;

endmodule

// File: tb/tb_fp_addsub_issue_ctrl.sv
// Scoreboard bench for fp_addsub_issue_ctrl: driver queues expected
// strobe cycle and operands, monitor checks each outsider15 pulse.
module tb_fp_addsub_issue_ctrl;

    localparam int DW = 32;
    localparam int L  = 4;
    localparam int LW = 8;

    localparam logic [DW-1:0] F0_5 = 32'h3F000000;
    localparam logic [DW-1:0] F1_0 = 32'h3F800000;
    localparam logic [DW-1:0] F2_0 = 32'h40000000;
    localparam logic [DW-1:0] F3_0 = 32'h40400000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] vec_len = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          in_op = 1'b0;
    logic [DW-1:0] a_out, b_out;
    logic          op_out, outsider15, busy, done;
    logic [LW-1:0] issued_cnt, result_cnt;

    fp_addsub_issue_ctrl #(.DATA_W(DW), .ADD_LATENCY(L), .LEN_W(LW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .a_out(a_out), .b_out(b_out), .op_out(op_out),
        .outsider15(outsider15), .busy(busy), .done(done),
        .issued_cnt(issued_cnt), .result_cnt(result_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct {
        logic [64:0] opnd;
        int          when;
    } exp_t;
    exp_t sb[$];

    // Stand-in for the adder pipeline: carries the operands it saw.
    logic [64:0] dly [L];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        dly[0] <= {op_out, a_out, b_out};
        for (int i = 1; i < L; i++) dly[i] <= dly[i-1];
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && outsider15) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 64'(outsider15), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_cycle", 64'(cyc), 64'(e.when));
                check("strobe_opnd_ab", dly[L-1][63:0], e.opnd[63:0]);
                check("strobe_op", 64'(dly[L-1][64]), 64'(e.opnd[64]));
            end
        end
    end

    // All driver tasks are entered and left on a falling edge.
    task automatic launch(input int len);
        vec_len = LW'(len);
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic op);
        bit ok;
        exp_t e;
        ok = 0;
        in_a = a;
        in_b = b;
        in_op = op;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) begin
                e.opnd = {op, a, b};
                e.when = cyc + 1 + L;
                sb.push_back(e);
                ok = 1;
            end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", 64'(in_ready), 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(input string nm);
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !done; i++) @(negedge clk);
        check(nm, 64'(done), 64'd1);
    endtask

    task automatic finish_vec(input int len);
        check("end_issued", 64'(issued_cnt), 64'(len));
        check("end_result", 64'(result_cnt), 64'(len));
        check("end_busy", 64'(busy), 64'd0);
        start = 1'b0;
        @(negedge clk);
        check("idle_done", 64'(done), 64'd0);
        check("idle_cnt", 64'(issued_cnt), 64'd0);
    endtask

    int acks;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_outs", {a_out, b_out}, 64'd0);
        check("rst_strobe", 64'(outsider15), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: three back-to-back pairs
        launch(3);
        send(F1_0, F2_0, 1'b0);
        send(F3_0, F1_0, 1'b1);
        send(F0_5, F0_5, 1'b0);
        in_valid = 1'b0;
        check("t1_in_ready_low", 64'(in_ready), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        wait_done("t1_done");
        finish_vec(3);

        // 2: in_valid alternating
        launch(4);
        send(F1_0, F1_0, 1'b0);
        idle(1);
        send(F2_0, F1_0, 1'b1);
        idle(1);
        send(F3_0, F0_5, 1'b0);
        idle(1);
        send(F0_5, F2_0, 1'b1);
        in_valid = 1'b0;
        check("t2_in_ready_low", 64'(in_ready), 64'd0);
        check("t2_issued", 64'(issued_cnt), 64'd4);
        wait_done("t2_done");
        finish_vec(4);

        // 3: more offered than requested
        launch(2);
        acks = 0;
        in_a = F2_0;
        in_b = F2_0;
        in_op = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (in_ready) begin
                exp_t e;
                e.opnd = {1'b0, F2_0, F2_0};
                e.when = cyc + 1 + L;
                sb.push_back(e);
                acks++;
            end
            @(negedge clk);
        end
        check("t3_acks", 64'(acks), 64'd2);
        wait_done("t3_done");
        finish_vec(2);

        // 4: abort after three, then a full rerun
        launch(6);
        send(F1_0, F2_0, 1'b0);
        send(F2_0, F3_0, 1'b0);
        send(F3_0, F0_5, 1'b1);
        in_valid = 1'b0;
        start = 1'b0;
        sb.delete();
        @(negedge clk);
        check("t4_abort_strobe", 64'(outsider15), 64'd0);
        check("t4_abort_issued", 64'(issued_cnt), 64'd0);
        check("t4_abort_busy", 64'(busy), 64'd0);
        check("t4_keep_a", 64'(a_out), 64'(F3_0));
        idle(8);
        launch(6);
        send(F0_5, F1_0, 1'b0);
        send(F1_0, F0_5, 1'b1);
        idle(2);
        send(F2_0, F2_0, 1'b0);
        send(F3_0, F2_0, 1'b1);
        send(F1_0, F3_0, 1'b0);
        idle(1);
        send(F0_5, F3_0, 1'b1);
        wait_done("t4_done");
        finish_vec(6);

        // 5: zero-length vector
        launch(0);
        check("t5_done", 64'(done), 64'd1);
        check("t5_ready", 64'(in_ready), 64'd0);
        repeat (3) @(negedge clk);
        check("t5_hold", 64'(done), 64'd1);
        check("t5_result", 64'(result_cnt), 64'd0);
        start = 1'b0;
        @(negedge clk);
        check("t5_idle", 64'(done), 64'd0);

        // 6: reset while draining
        launch(3);
        send(F1_0, F1_0, 1'b0);
        send(F2_0, F2_0, 1'b0);
        send(F3_0, F3_0, 1'b1);
        in_valid = 1'b0;
        check("t6_drain", {62'd0, busy, in_ready}, 64'd2);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        sb.delete();
        #1;
        check("t6_async_busy", 64'(busy), 64'd0);
        check("t6_async_outs", {a_out, b_out}, 64'd0);
        check("t6_async_cnt", 64'(issued_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check("t6_idle", {62'd0, busy, done}, 64'd0);
        launch(1);
        send(F0_5, F1_0, 1'b1);
        wait_done("t6_rerun_done");
        finish_vec(1);

        idle(L + 4);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
